// File: rtl/m_dispatch_pkg.sv
// Shared types for the M-extension dispatch stage.
// Opcode/funct constants, FSM states, FIFO entry.
package m_dispatch_pkg;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } func3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    function automatic logic is_m_op(input logic [31:0] instr);
        return (instr[6:0] == OPC_OP) && (instr[31:25] == FUNCT7_M);
    endfunction

    // Divide/remainder (funct3[2] set) with a zero divisor.
    function automatic logic is_div0(input entry_t e);
        return e.instruction[14] && (e.rs2 == 32'd0);
    endfunction

endpackage

// File: rtl/m_dispatch_fifo.sv
// Synchronous FIFO for queued M ops.
// Extra pointer wrap bit separates full from empty.
module m_dispatch_fifo
    import m_dispatch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    T           mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset drops every stored entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/m_unit_dispatch.sv
// Issue stage in front of riscv_m_unit: FIFO, one-op FSM, watchdog.
// Optional macro M_DISPATCH_DIV0_BYPASS_EN resolves divide-by-zero locally.
module m_unit_dispatch
    import m_dispatch_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        m_valid,
    output logic [31:0] m_instruction,
    output logic [31:0] m_rs1,
    output logic [31:0] m_rs2,
    input  logic        m_wr,
    input  logic [31:0] m_rd,
    input  logic        m_busy,
    input  logic        m_ready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        idle
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    state_t        state_q, state_d;
    logic [31:0]   m_instr_q, m_instr_d;
    logic [31:0]   m_rs1_q, m_rs1_d;
    logic [31:0]   m_rs2_q, m_rs2_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_err_q, wb_err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    entry_t in_entry;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;

    assign in_entry  = '{instruction: in_instruction, rs1: in_rs1, rs2: in_rs2};
    assign in_ready  = !fifo_full;
    // Non-M ops are handshaken but never stored.
    assign fifo_push = in_valid && !fifo_full && is_m_op(in_instruction);

    m_dispatch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (fifo_push),
        .wdata_i (in_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: one op in flight, strictly in order.
    always_comb begin
        state_d   = state_q;
        m_instr_d = m_instr_q;
        m_rs1_d   = m_rs1_q;
        m_rs2_d   = m_rs2_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_err_d  = wb_err_q;
        tmo_d     = tmo_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
`ifdef M_DISPATCH_DIV0_BYPASS_EN
                    if (is_div0(head)) begin
                        fifo_pop  = 1'b1;
                        wb_rd_d   = head.instruction[11:7];
                        wb_data_d = head.instruction[13] ? head.rs1 : 32'hFFFF_FFFF;
                        wb_err_d  = 1'b0;
                        state_d   = WB;
                    end else if (!m_busy) begin
`else
                    if (!m_busy) begin
`endif
                        fifo_pop  = 1'b1;
                        m_instr_d = head.instruction;
                        m_rs1_d   = head.rs1;
                        m_rs2_d   = head.rs2;
                        wb_rd_d   = head.instruction[11:7];
                        tmo_d     = '0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (m_ready && m_wr) begin
                    wb_data_d = m_rd;
                    wb_err_d  = 1'b0;
                    state_d   = WB;
                end else if (m_ready) begin
                    state_d = IDLE;
                end else if (tmo_q == TO_LAST) begin
                    wb_data_d = '0;
                    wb_err_d  = 1'b1;
                    state_d   = WB;
                end else begin
                    tmo_d = tmo_q + TO_ONE;
                end
            end
            WB: if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            m_instr_q <= '0;
            m_rs1_q   <= '0;
            m_rs2_q   <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_instr_q <= m_instr_d;
            m_rs1_q   <= m_rs1_d;
            m_rs2_q   <= m_rs2_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign m_valid       = (state_q == ISSUE);
    assign m_instruction = m_instr_q;
    assign m_rs1         = m_rs1_q;
    assign m_rs2         = m_rs2_q;
    assign wb_valid      = (state_q == WB);
    assign wb_rd_addr    = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_err        = wb_err_q;
    assign idle          = fifo_empty && (state_q == IDLE);

endmodule
